seq_mult_queue: RTL and testbench

//  Parametrised iterative shift-add multiplier behind start/getResult method handshakes.

---
 rtl/seq_mult_pkg.sv | 12 +
 rtl/seq_mult_queue_result_fifo.sv | 60 ++++++
 rtl/seq_mult_queue.sv | 87 ++++++++
 tb/tb_seq_mult_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and default sizing for the iterative multiplier with result queue.
package seq_mult_pkg;
  localparam int BYTE       = 8;
  localparam int WORD       = 4 * BYTE;
  localparam int DATA_WIDTH = WORD;
  localparam int RES_DEPTH  = 4;
  localparam int PROD_W     = 2 * DATA_WIDTH;
  localparam int CNT_W      = $clog2(DATA_WIDTH);
  localparam int OCC_W      = $clog2(RES_DEPTH + 1);

  typedef enum logic {IDLE, BUSY} state_e;
endpackage

// File: rtl/seq_mult_queue_result_fifo.sv
// Sync FIFO whose head entry and non-empty flag are presented from registers.
module result_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               head_o,
  output logic                           valid_o,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]            occ_q, occ_d;
  logic [WIDTH-1:0]            head_q, head_d;
  logic                        valid_q;

  always_comb begin
    occ_d = occ_q;
    if (push_i && !pop_i)      occ_d = occ_q + OCC_W'(1);
    else if (!push_i && pop_i) occ_d = occ_q - OCC_W'(1);

    // Head only changes when the visible entry is replaced; otherwise it holds.
    head_d = head_q;
    if (push_i && (occ_q == '0 || (pop_i && occ_q == OCC_W'(1))))
      head_d = push_data_i;
    else if (pop_i && occ_q > OCC_W'(1))
      head_d = mem_q[rd_ptr_q + PTR_W'(1)];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q   <= occ_d;
      head_q  <= head_d;
      valid_q <= (occ_d != '0);
    end
  end

  assign head_o      = head_q;
  assign valid_o     = valid_q;
  assign occupancy_o = occ_q;
endmodule

// File: rtl/seq_mult_queue.sv
// Shift-add multiplier, one multiplier bit per cycle, feeding a result queue.
module seq_mult_queue
  import seq_mult_pkg::*;
#(
  parameter int DATA_WIDTH = WORD,
  parameter int RES_DEPTH  = 4,
  parameter int SIGNED_EN  = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [DATA_WIDTH-1:0]              start_a_i,
  input  logic [DATA_WIDTH-1:0]              start_b_i,
  input  logic                               start_signed_i,
  input  logic                               start_en_i,
  output logic                               start_rdy_o,
  input  logic                               getResult_en_i,
  output logic                               getResult_rdy_ff_o,
  output logic [2*DATA_WIDTH-1:0]            getResult_data_ff_o,
  output logic [$clog2(RES_DEPTH+1)-1:0]     occupancy_o
);
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam int OW = $clog2(RES_DEPTH + 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   a_q, acc_q, acc_d, prod;
  logic [DW-1:0]   b_q, mag_a, mag_b;
  logic            neg_q, sgn, neg, start_fire, push, pop;

  assign start_rdy_o = (state_q == IDLE) && (occupancy_o < OW'(RES_DEPTH));
  assign start_fire  = start_en_i && start_rdy_o;
  assign pop         = getResult_en_i && getResult_rdy_ff_o;
  assign push        = (state_q == BUSY) && (cnt_q == CW'(DW - 1));

  always_comb begin
    sgn   = (SIGNED_EN != 0) && start_signed_i;
    // W-bit magnitude keeps -2^(W-1) exact as unsigned 2^(W-1).
    mag_a = (sgn && start_a_i[DW-1]) ? (~start_a_i + DW'(1)) : start_a_i;
    mag_b = (sgn && start_b_i[DW-1]) ? (~start_b_i + DW'(1)) : start_b_i;
    neg   = sgn && (start_a_i[DW-1] ^ start_b_i[DW-1]);
    acc_d = acc_q + (b_q[0] ? a_q : '0);
    prod  = neg_q ? (~acc_d + PW'(1)) : acc_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_fire) begin
          a_q     <= PW'(mag_a);
          b_q     <= mag_b;
          acc_q   <= '0;
          cnt_q   <= '0;
          neg_q   <= neg;
          state_q <= BUSY;
        end
        BUSY: begin
          acc_q <= acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (push) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  result_fifo #(.WIDTH(PW), .DEPTH(RES_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (prod),
    .pop_i       (pop),
    .head_o      (getResult_data_ff_o),
    .valid_o     (getResult_rdy_ff_o),
    .occupancy_o (occupancy_o)
  );
endmodule

// File: tb/tb_seq_mult_queue.sv
// Self-checking bench: directed table, queue corner sequences, random traffic vs model.
module tb_seq_mult_queue;
  localparam int W = 32;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [W-1:0] start_a = '0, start_b = '0;
  logic        start_signed = 1'b0, start_en = 1'b0, get_en = 1'b0;
  logic        start_rdy, get_rdy;
  logic [2*W-1:0] get_data;
  logic [2:0]  occ;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] mq[$];

  always #5 clk = ~clk;

  seq_mult_queue #(.DATA_WIDTH(W), .RES_DEPTH(D), .SIGNED_EN(1)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .start_a_i           (start_a),
    .start_b_i           (start_b),
    .start_signed_i      (start_signed),
    .start_en_i          (start_en),
    .start_rdy_o         (start_rdy),
    .getResult_en_i      (get_en),
    .getResult_rdy_ff_o  (get_rdy),
    .getResult_data_ff_o (get_data),
    .occupancy_o         (occ)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] exp;
  } vec_t;

  // Reference product: extend per mode, multiply, keep the low 2W bits.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic [2*W-1:0] x, y;
    x = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    y = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return x * y;
  endfunction

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n = 0;
    while (!start_rdy && n < 200) begin @(negedge clk); n++; end
    if (!start_rdy) chk("start_rdy_timeout", 64'(start_rdy), 64'd1);
    start_a = a; start_b = b; start_signed = s; start_en = 1'b1;
    @(negedge clk);
    start_en = 1'b0;
    mq.push_back(model(a, b, s));
  endtask

  task automatic wait_rdy(output int cyc);
    cyc = 0;
    while (!get_rdy && cyc < 200) begin @(negedge clk); cyc++; end
    if (!get_rdy) chk("result_timeout", 64'(get_rdy), 64'd1);
  endtask

  task automatic pop_chk(input string name);
    chk(name, get_data, (mq.size() > 0) ? mq[0] : '0);
    get_en = 1'b1;
    @(negedge clk);
    get_en = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  function automatic logic [W-1:0] pick(input int k);
    case (k)
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t vt[8];
    int cyc;

    vt[0] = '{32'd3,          32'd5,          1'b0, 64'h0000_0000_0000_000F};
    vt[1] = '{32'hFFFF_FFFD,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
    vt[2] = '{32'hFFFF_FFFD,  32'd5,          1'b0, 64'h0000_0004_FFFF_FFF1};
    vt[3] = '{32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000};
    vt[4] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001};
    vt[5] = '{32'h7FFF_FFFF,  32'h8000_0000,  1'b1, 64'hC000_0000_8000_0000};
    vt[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 64'h0000_0000_0000_0001};
    vt[7] = '{32'h0,          32'h1234_5678,  1'b1, 64'h0};

    repeat (2) @(negedge clk);
    chk("reset_rdy", 64'(get_rdy), 64'd0);
    chk("reset_data", get_data, 64'd0);
    chk("reset_occ", 64'(occ), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_start_rdy", 64'(start_rdy), 64'd1);

    foreach (vt[i]) begin
      start_op(vt[i].a, vt[i].b, vt[i].s);
      wait_rdy(cyc);
      if (i == 0) chk("latency", 64'(cyc), 64'(W));
      chk($sformatf("vec%0d_data", i), get_data, vt[i].exp);
      chk($sformatf("vec%0d_occ", i), 64'(occ), 64'd1);
      pop_chk($sformatf("vec%0d_pop", i));
      chk($sformatf("vec%0d_empty", i), 64'(get_rdy), 64'd0);
    end

    // Fill the queue, confirm backpressure, then drain in issue order.
    for (int i = 0; i < D; i++) start_op($urandom, $urandom, 1'(i));
    repeat (W + 2) @(negedge clk);
    chk("full_occ", 64'(occ), 64'(D));
    chk("full_start_rdy", 64'(start_rdy), 64'd0);
    start_en = 1'b1;
    repeat (3) @(negedge clk);
    start_en = 1'b0;
    chk("full_ignored_start", 64'(occ), 64'(D));
    pop_chk("full_pop0");
    chk("after_pop_start_rdy", 64'(start_rdy), 64'd1);
    chk("after_pop_occ", 64'(occ), 64'(D - 1));
    for (int i = 1; i < D; i++) pop_chk($sformatf("full_pop%0d", i));
    chk("drained_occ", 64'(occ), 64'd0);

    // Pop the lone entry on the same edge the next product is pushed.
    start_op(32'd11, 32'd13, 1'b0);
    wait_rdy(cyc);
    start_op(32'hFFFF_FFF9, 32'd9, 1'b1);
    repeat (W - 1) @(posedge clk);
    @(negedge clk);
    chk("pp_head_before", get_data, 64'd143);
    chk("pp_occ_before", 64'(occ), 64'd1);
    get_en = 1'b1;
    @(negedge clk);
    get_en = 1'b0;
    void'(mq.pop_front());
    chk("pp_occ_after", 64'(occ), 64'd1);
    chk("pp_head_after", get_data, 64'hFFFF_FFFF_FFFF_FFC1);
    pop_chk("pp_final_pop");

    // Asynchronous reset mid-operation with two results queued.
    start_op(32'd2, 32'd3, 1'b0);
    wait_rdy(cyc);
    start_op(32'd4, 32'd5, 1'b0);
    wait_rdy(cyc);
    start_op(32'd8, 32'd9, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rdy", 64'(get_rdy), 64'd0);
    chk("arst_data", get_data, 64'd0);
    chk("arst_occ", 64'(occ), 64'd0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(32'd7, 32'd6, 1'b0);
    wait_rdy(cyc);
    chk("post_reset_42", get_data, 64'd42);
    pop_chk("post_reset_pop");

    // Random traffic: issue and collect at random, compare each pop with the model queue.
    for (int c = 0; c < 3000; c++) begin
      logic popped;
      popped = 1'b0;
      if (start_rdy && $urandom_range(0, 3) == 0) begin
        start_a = pick($urandom_range(0, 3));
        start_b = pick($urandom_range(0, 3));
        start_signed = 1'($urandom_range(0, 1));
        start_en = 1'b1;
        mq.push_back(model(start_a, start_b, start_signed));
      end
      if (get_rdy && $urandom_range(0, 2) == 0) begin
        chk("rand_pop", get_data, (mq.size() > 0) ? mq[0] : '0);
        get_en = 1'b1;
        popped = 1'b1;
      end
      @(negedge clk);
      if (popped && mq.size() > 0) void'(mq.pop_front());
      start_en = 1'b0;
      get_en = 1'b0;
    end
    while (mq.size() > 0) begin
      wait_rdy(cyc);
      if (!get_rdy) break;
      pop_chk("rand_drain");
    end
    repeat (2) @(negedge clk);
    chk("final_occ", 64'(occ), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
